// File: rtl/addsub_pkg.sv
// Shared constants for the arbitrated add/subtract unit: FSM encoding, op codes, default width.
package addsub_pkg;
  localparam int WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor; subtract is A + ~B + 1, so carry=1 means no borrow.
// Optional signed-overflow flag when ADDSUB_OVF_EN is defined.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  always_comb begin
    b_eff = (sub_i == OP_SUB) ? ~b_i : b_i;
    total = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
  end

  assign sum_o   = total[WIDTH-1:0];
  assign carry_o = total[WIDTH];

`ifdef ADDSUB_OVF_EN
  // Overflow: like-signed operands (after B inversion) producing an opposite-signed result.
  assign ovf_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
`endif

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one addsub_core between two requesters, one operation in flight.
// Optional out_ovf port enabled by defining ADDSUB_OVF_EN.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_id
`ifdef ADDSUB_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  state_e           state_q, state_d;
  logic             ptr_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q, id_q;
  logic             out_valid_q, out_carry_q, out_id_q;
  logic [WIDTH-1:0] out_result_q;
  logic             grant_vld, grant_id, accept;
  logic [WIDTH-1:0] core_sum;
  logic             core_carry;

  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    accept    = (state_q == IDLE) && !reset && grant_vld;
  end

  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture is data only; it is qualified by accept, which is already low in reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= grant_id ? req1_a : req0_a;
      b_q   <= grant_id ? req1_b : req0_b;
      sub_q <= grant_id ? req1_sub : req0_sub;
      id_q  <= grant_id;
    end
  end

`ifdef ADDSUB_OVF_EN
  logic core_ovf, out_ovf_q;
`endif

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a_i     (a_q),
    .b_i     (b_q),
    .sub_i   (sub_q),
    .sum_o   (core_sum),
    .carry_o (core_carry)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf_o   (core_ovf)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_id_q     <= 1'b0;
`ifdef ADDSUB_OVF_EN
      out_ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) ptr_q <= ~grant_id;
      if (state_q == EXEC) begin
        out_valid_q  <= 1'b1;
        out_result_q <= core_sum;
        out_carry_q  <= core_carry;
        out_id_q     <= id_q;
`ifdef ADDSUB_OVF_EN
        out_ovf_q    <= core_ovf;
`endif
      end else if (state_q == HOLD && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_id     = out_id_q;
`ifdef ADDSUB_OVF_EN
  assign out_ovf    = out_ovf_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: per-cycle comparison against a transaction-level model plus
// directed literal checks. Build with ADDSUB_OVF_EN defined to also cover out_ovf.
module tb_addsub_arbiter;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         out_valid, out_ready, out_carry, out_id;
  logic [W-1:0] out_result;
`ifdef ADDSUB_OVF_EN
  logic         out_ovf;
`endif

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_id     (out_id)
`ifdef ADDSUB_OVF_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 = free, 1 = operation taken, 2 = result presented.
  bit       m_init = 1'b0;
  int       m_phase = 0;
  int       m_ptr = 0;
  int       m_a, m_b, m_sub, m_id;
  int       m_ov, m_res, m_carry, m_oid, m_ovf;
  int       ai, bi, r, sa, sb, rs;
  bit       e0, e1;

  always @(negedge clk) begin
    e0 = !reset && m_phase == 0 && req0_valid && (!req1_valid || m_ptr == 0);
    e1 = !reset && m_phase == 0 && req1_valid && (!req0_valid || m_ptr == 1);
    if (m_init) begin
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("out_valid", out_valid, m_ov);
      chk("out_result", out_result, m_res);
      chk("out_carry", out_carry, m_carry);
      chk("out_id", out_id, m_oid);
`ifdef ADDSUB_OVF_EN
      chk("out_ovf", out_ovf, m_ovf);
`endif
    end
    if (reset) begin
      m_init = 1'b1; m_phase = 0; m_ptr = 0;
      m_ov = 0; m_res = 0; m_carry = 0; m_oid = 0; m_ovf = 0;
    end else if (m_init) begin
      case (m_phase)
        0: if (e0 || e1) begin
          m_id  = e1 ? 1 : 0;
          m_a   = e1 ? int'(req1_a) : int'(req0_a);
          m_b   = e1 ? int'(req1_b) : int'(req0_b);
          m_sub = e1 ? int'(req1_sub) : int'(req0_sub);
          m_ptr = e1 ? 0 : 1;
          m_phase = 1;
        end
        1: begin
          ai = m_a; bi = m_b;
          r = (m_sub != 0) ? ai - bi : ai + bi;
          m_res   = (r + 64) % 64;
          m_carry = (m_sub != 0) ? int'(ai >= bi) : int'(r >= 64);
          sa = (ai >= 32) ? ai - 64 : ai;
          sb = (bi >= 32) ? bi - 64 : bi;
          rs = (m_sub != 0) ? sa - sb : sa + sb;
          m_ovf = int'(rs > 31 || rs < -32);
          m_oid = m_id;
          m_ov  = 1;
          m_phase = 2;
        end
        default: if (out_ready) begin
          m_ov = 0;
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic issue(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub);
    bit got;
    @(posedge clk); #1;
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) got = 1'b1;
    end
    chk("issue_handshake", got, 1);
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input int res, input int carry, input int id);
    @(negedge clk);
    chk({tag, "_exec_valid"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, out_result, res);
    chk({tag, "_carry"}, out_carry, carry);
    chk({tag, "_id"}, out_id, id);
  endtask

  int gseq[$];

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_carry", out_carry, 0);
    chk("rst_id", out_id, 0);

    issue(0, 6'd23, 6'd15, 1'b1);
    check_result("p0_sub", 8, 1, 0);
    issue(1, 6'd60, 6'd10, 1'b0);
    check_result("p1_wrap", 6, 1, 1);
`ifdef ADDSUB_OVF_EN
    chk("p1_wrap_ovf", out_ovf, 0);
`endif
    issue(0, 6'd5, 6'd9, 1'b1);
    check_result("p0_borrow", 60, 0, 0);
`ifdef ADDSUB_OVF_EN
    issue(0, 6'd31, 6'd1, 1'b0);
    check_result("p0_ovf", 32, 0, 0);
    chk("p0_ovf_flag", out_ovf, 1);
`endif

    // Both requesters continuously valid right after reset.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req0_valid = 1'b1; req0_a = 6'd1;  req0_b = 6'd2;  req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 6'd40; req1_b = 6'd50; req1_sub = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready) gseq.push_back(0);
      if (req1_ready) gseq.push_back(1);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    chk("grant_count", gseq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("grant_seq", (i < gseq.size()) ? gseq[i] : -1, i % 2);

    // Consumer stalls in HOLD while port 0 keeps requesting.
    out_ready = 1'b0;
    issue(1, 6'd7, 6'd3, 1'b0);
    req0_valid = 1'b1; req0_a = 6'd3; req0_b = 6'd3; req0_sub = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", out_result, 10);
      chk("hold_id", out_id, 1);
      chk("hold_rdy0", req0_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("rel_valid_before", out_valid, 1);
    @(negedge clk);
    chk("rel_valid_after", out_valid, 0);
    chk("rel_rdy0", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Reset while an operation is in EXEC; pointer would otherwise favour port 1.
    issue(0, 6'd1, 6'd1, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req0_valid = 1'b1; req0_a = 6'd9;  req0_b = 6'd4;  req0_sub = 1'b1;
    req1_valid = 1'b1; req1_a = 6'd33; req1_b = 6'd33; req1_sub = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rdy0", req0_ready, 1);
    chk("mid_rst_rdy1", req1_ready, 0);
    repeat (6) @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one combinational 6-bit adder/subtractor core between two requesters (port 0, port 1).
- Sequences each operation through a small FSM:
  - latches operands on a valid/ready handshake;
  - evaluates in the core;
  - registers the result;
  - holds the result until the consumer accepts it.
- Sits between operand-producing control logic and the shared arithmetic datapath; one operation in flight at a time.

Parameters:
- WIDTH, 6, operand/result width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 accepted this cycle.
- req0_a  input  WIDTH  port 0 operand A.
- req0_b  input  WIDTH  port 0 operand B.
- req0_sub  input  1  port 0 op: 0 = A+B, 1 = A−B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as port 0, for port 1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  registered result, mod 2^WIDTH.
- out_carry  output  1  carry-out of the core. For subtract, 1 means no borrow (A ≥ B unsigned).
- out_id  output  1  requester that issued the result.

Behaviour:
- Interface is decided: one clock `clk`; `reset` is synchronous, active-high.
- Reset values: FSM = IDLE, round-robin pointer = 0, all outputs 0 (including req*_ready and out_valid).
- FSM states: IDLE, EXEC, HOLD.
  - **IDLE**
    - If exactly one reqN_valid is high, grant it.
    - If both are high, grant the port named by the pointer.
    - On grant: reqN_ready = 1 combinationally in that cycle (only when in IDLE and not in reset).
    - The clock edge latches a, b, sub and id; pointer ← ~granted_id; next state EXEC.
    - No valid: stay in IDLE, pointer unchanged.
  - **EXEC**
    - Core evaluates latched operands: A + B, or A + ~B + 1 for subtract.
    - Edge: out_result, out_carry, out_id registered; out_valid ← 1; next state HOLD.
  - **HOLD**
    - out_valid = 1; outputs stable.
    - When out_ready = 1, the edge clears out_valid and returns to IDLE.
- req*_ready is 0 in EXEC and HOLD. A new request is accepted only from IDLE, in the cycle after the HOLD handshake; there is no bypass.
- Latency:
  - Handshake at edge N gives out_valid high after edge N+1.
  - Minimum issue interval is 3 cycles, with out_ready tied high.
- Arithmetic:
  - Result is WIDTH bits with wrap-around; the carry is the (WIDTH+1)th bit.
  - Inputs are not interpreted as signed.
- Requester valid deassertion before ready is legal; the request is then simply not taken.
- Reset mid-operation (EXEC or HOLD): the operation is discarded, out_valid drops after the reset edge, and the pointer returns to 0.
- Operand changes on a requester after its handshake have no effect.

Optional Feature:
- Macro: ADDSUB_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), registered alongside out_result.
  - out_ovf is set on two's-complement signed overflow: operand sign bits equal (B inverted for subtract) and the result sign differs.
  - Reset value 0.
- Undefined:
  - Port absent; no overflow logic.

Decomposition:
- Shared package `addsub_pkg`:
  - state encoding: IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2;
  - OP_ADD = 1'b0, OP_SUB = 1'b1;
  - default WIDTH constant.
- One natural sub-module, `addsub_core`:
  - purely combinational (a, b, sub) → (sum, carry[, ovf]);
  - instantiated once, fed from the latched operand registers.

Test Plan:
- Port 0 only: a=23, b=15, sub=1 → out_result=6'b001000 (8), out_carry=1, out_id=0, out_valid high 2 cycles after handshake.
- Port 1 only: a=60, b=10, sub=0 → out_result=6 (wrap), out_carry=1, out_id=1. With ADDSUB_OVF_EN: out_ovf=0.
- Port 0: a=5, b=9, sub=1 → out_result=60 (6'b111100), out_carry=0. With ADDSUB_OVF_EN: a=31, b=1, sub=0 → result 32, out_ovf=1.
- Both valid continuously after reset → grants alternate 0, 1, 0, 1. Each req*_ready pulses one cycle. out_id follows the same sequence. Pointer is 0 after reset.
- Hold out_ready=0 for 4 cycles in HOLD → out_result/out_id stable, req*_ready stays 0. Then out_ready=1 → out_valid drops, and a new grant is possible the cycle after.
- Assert reset during EXEC → next cycle out_valid=0, state IDLE. A subsequent dual request grants port 0 first.
